// File: rtl/multicore_sobel_cpu_1_oci_dct_packer.sv
// -----------------------------------------------------------------------------
// multicore_sobel_cpu_1_oci_dct_packer
//
// Packs 2-bit direct-conditional trace atoms from CPU_1 into frames of up to
// MAX_ATOMS atoms. Completed frames go downstream through a one-entry
// valid/ready register slice. The trace source cannot stall, so an atom that
// arrives while the buffer is full and the slot is busy is dropped and flagged.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   trace_enable      qualifies atom_valid; buffer is retained while low
//   atom_valid, atom  incoming atom and its strobe
//   flush             close the current partial frame (single-cycle pulse)
//   frame_ready       downstream accepts the presented frame
//   overflow_clr      clears the sticky overflow flag
//   frame_valid       frame slot occupied
//   frame_data        packed frame, oldest atom in the highest occupied bits
//   frame_count       atoms in the presented frame, 1..MAX_ATOMS
//   dct_buffer        live accumulation buffer
//   dct_count         live atom count, 0..MAX_ATOMS
//   overflow          sticky: at least one atom was dropped
// -----------------------------------------------------------------------------
module multicore_sobel_cpu_1_oci_dct_packer #(
    parameter int unsigned ATOM_W    = 2,
    parameter int unsigned MAX_ATOMS = 15,
    localparam int unsigned BUF_W    = MAX_ATOMS * ATOM_W,
    localparam int unsigned CNT_W    = $clog2(MAX_ATOMS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trace_enable,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom,
    input  logic              flush,
    input  logic              frame_ready,
    input  logic              overflow_clr,
    output logic              frame_valid,
    output logic [BUF_W-1:0]  frame_data,
    output logic [CNT_W-1:0]  frame_count,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_ATOMS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Flush seen while the slot was busy; the partial frame leaves later.
    logic flush_pend;

    // Next-state values
    logic              frame_valid_n;
    logic [BUF_W-1:0]  frame_data_n;
    logic [CNT_W-1:0]  frame_count_n;
    logic [BUF_W-1:0]  dct_buffer_n;
    logic [CNT_W-1:0]  dct_count_n;
    logic              overflow_n;
    logic              flush_pend_n;

    // Control terms, all derived from registered state and current inputs
    logic acc;
    logic slot_free;
    logic buf_full;
    logic buf_empty;
    logic xfer;
    logic drop;

    assign acc       = trace_enable & atom_valid;
    assign slot_free = ~frame_valid | frame_ready;
    assign buf_full  = (dct_count == CNT_FULL);
    assign buf_empty = (dct_count == '0);
    assign xfer      = slot_free & (buf_full | ((flush | flush_pend) & ~buf_empty));
    // A full buffer that cannot transfer has nowhere to put a new atom.
    assign drop      = acc & buf_full & ~xfer;

    // Next-state logic for buffer, frame slot, flush and overflow tracking
    always_comb begin
        frame_valid_n = frame_valid;
        frame_data_n  = frame_data;
        frame_count_n = frame_count;
        dct_buffer_n  = dct_buffer;
        dct_count_n   = dct_count;
        overflow_n    = overflow;
        flush_pend_n  = flush_pend;

        if (xfer) begin
            // Transfer takes the pre-atom buffer; a coincident atom opens the next frame.
            frame_valid_n = 1'b1;
            frame_data_n  = dct_buffer;
            frame_count_n = dct_count;
            flush_pend_n  = 1'b0;
            if (acc) begin
                dct_buffer_n = BUF_W'(atom);
                dct_count_n  = CNT_ONE;
            end else begin
                dct_buffer_n = '0;
                dct_count_n  = '0;
            end
        end else begin
            if (frame_valid && frame_ready) begin
                frame_valid_n = 1'b0;
            end
            // Slot busy with a partial frame: remember the flush.
            if (flush && !buf_empty) begin
                flush_pend_n = 1'b1;
            end
            if (acc && !buf_full) begin
                dct_buffer_n = {dct_buffer[BUF_W-ATOM_W-1:0], atom};
                dct_count_n  = dct_count + CNT_ONE;
            end
        end

        // A drop wins over a coincident clear.
        if (drop) begin
            overflow_n = 1'b1;
        end else if (overflow_clr) begin
            overflow_n = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_count <= '0;
            dct_buffer  <= '0;
            dct_count   <= '0;
            overflow    <= 1'b0;
            flush_pend  <= 1'b0;
        end else begin
            frame_valid <= frame_valid_n;
            frame_data  <= frame_data_n;
            frame_count <= frame_count_n;
            dct_buffer  <= dct_buffer_n;
            dct_count   <= dct_count_n;
            overflow    <= overflow_n;
            flush_pend  <= flush_pend_n;
        end
    end

endmodule

// File: tb/tb_multicore_sobel_cpu_1_oci_dct_packer.sv
// -----------------------------------------------------------------------------
// Testbench for multicore_sobel_cpu_1_oci_dct_packer.
// A reference model keeps the live buffer as a queue of atom codes and packs
// frames arithmetically; frames it emits go into a scoreboard queue that a
// separate monitor drains whenever the DUT hands a frame downstream.
// -----------------------------------------------------------------------------
module tb_multicore_sobel_cpu_1_oci_dct_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        t_en = 1'b0;
    logic        a_v = 1'b0;
    logic [1:0]  a = 2'b00;
    logic        fl = 1'b0;
    logic        rdy = 1'b0;
    logic        oclr = 1'b0;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;

    always #5 clk = ~clk;

    multicore_sobel_cpu_1_oci_dct_packer dut (
        .clk          (clk),
        .reset_n      (rst_n),
        .trace_enable (t_en),
        .atom_valid   (a_v),
        .atom         (a),
        .flush        (fl),
        .frame_ready  (rdy),
        .overflow_clr (oclr),
        .frame_valid  (frame_valid),
        .frame_data   (frame_data),
        .frame_count  (frame_count),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .overflow     (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [3:0]  cnt;
        logic [29:0] data;
    } frame_t;

    frame_t      exp_q[$];
    int          m_q[$];      // live buffer, oldest atom first
    bit          m_pend;
    bit          m_fv;
    bit          m_ovf;
    logic [29:0] m_fd;
    int          m_fc;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Oldest atom is the most significant base-4 digit.
    function automatic logic [29:0] pack_atoms(input int q[$]);
        longint d = 0;
        foreach (q[i]) d = d * 4 + longint'(q[i]);
        return 30'(d);
    endfunction

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_pend = 0;
        m_fv   = 0;
        m_ovf  = 0;
        m_fd   = '0;
        m_fc   = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs held this cycle.
    task automatic model_step();
        bit     acc, slot_free, go, dropped;
        int     n;
        frame_t f;
        acc       = t_en && a_v;
        n         = m_q.size();
        slot_free = !m_fv || rdy;
        go        = slot_free && (n == 15 || ((fl || m_pend) && n != 0));
        dropped   = 0;
        if (go) begin
            m_fd   = pack_atoms(m_q);
            m_fc   = n;
            m_fv   = 1;
            m_pend = 0;
            f.cnt  = 4'(n);
            f.data = m_fd;
            exp_q.push_back(f);
            m_q.delete();
            if (acc) m_q.push_back(int'(a));
        end else begin
            if (m_fv && rdy) m_fv = 0;
            if (fl && n != 0) m_pend = 1;
            if (acc) begin
                if (n < 15) m_q.push_back(int'(a));
                else dropped = 1;
            end
        end
        if (dropped) m_ovf = 1;
        else if (oclr) m_ovf = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic drive(input logic en, input logic v, input logic [1:0] at,
                         input logic f, input logic r, input logic c);
        t_en = en; a_v = v; a = at; fl = f; rdy = r; oclr = c;
    endtask

    task automatic idle(input int n);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        repeat (n) cycle();
    endtask

    // Monitor: live state against the model, handed-off frames against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("dct_count",   64'(dct_count),   64'(m_q.size()));
            check("dct_buffer",  64'(dct_buffer),  64'(pack_atoms(m_q)));
            check("overflow",    64'(overflow),    64'(m_ovf));
            check("frame_valid", 64'(frame_valid), 64'(m_fv));
            if (m_fv) begin
                check("frame_data_hold",  64'(frame_data),  64'(m_fd));
                check("frame_count_hold", 64'(frame_count), 64'(m_fc));
            end
            if (frame_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 64'(frame_valid), 64'(0));
                end else begin
                    frame_t e;
                    e = exp_q.pop_front();
                    check("sb_frame_data",  64'(frame_data),  64'(e.data));
                    check("sb_frame_count", 64'(frame_count), 64'(e.cnt));
                end
            end
        end
    end

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_frame_valid", 64'(frame_valid), 64'(0));
        check("rst_dct_count",   64'(dct_count),   64'(0));
        check("rst_overflow",    64'(overflow),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-frame
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 2'(i), 1'b0, 1'b1, 1'b0);
            cycle();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_frame_valid", 64'(frame_valid), 64'(0));
        check("arst_frame_data",  64'(frame_data),  64'(0));
        check("arst_frame_count", 64'(frame_count), 64'(0));
        check("arst_dct_buffer",  64'(dct_buffer),  64'(0));
        check("arst_dct_count",   64'(dct_count),   64'(0));
        check("arst_overflow",    64'(overflow),    64'(0));
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("post_rst_no_frame", 64'(frame_valid), 64'(0));

        // Full frame of 2'b01
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
            cycle();
        end
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        cycle();
        check("full_frame_valid", 64'(frame_valid), 64'(1));
        check("full_frame_data",  64'(frame_data),  64'(30'h15555555));
        check("full_frame_count", 64'(frame_count), 64'(15));
        check("full_dct_count",   64'(dct_count),   64'(0));
        idle(2);

        // Partial frame by flush
        drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0); cycle();
        check("flush_frame_data",  64'(frame_data),  64'(30'h39));
        check("flush_frame_count", 64'(frame_count), 64'(3));
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0); cycle();
        cycle();
        check("empty_flush_no_frame", 64'(frame_valid), 64'(0));
        idle(2);

        // Slot blocked: hold, overflow, back-to-back hand-off, clear
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 1'b1, 2'($urandom_range(3)), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        check("blk_frame_valid", 64'(frame_valid), 64'(1));
        check("blk_frame_count", 64'(frame_count), 64'(15));
        check("blk_dct_count",   64'(dct_count),   64'(15));
        check("blk_overflow",    64'(overflow),    64'(1));
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0); cycle();
        check("b2b_frame_valid", 64'(frame_valid), 64'(1));
        check("b2b_frame_count", 64'(frame_count), 64'(15));
        check("b2b_dct_count",   64'(dct_count),   64'(0));
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1); cycle();
        check("ovf_clr", 64'(overflow), 64'(0));
        idle(2);

        // Flush while slot busy, atoms append to the pending frame
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0); cycle();
        end
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0); cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 2'(i), 1'b0, 1'b0, 1'b0); cycle();
        end
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0); cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0); cycle();
        end
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0); cycle();
        check("pend_frame_valid", 64'(frame_valid), 64'(1));
        check("pend_frame_count", 64'(frame_count), 64'(6));
        idle(3);

        // Atom coincident with a full-buffer transfer, then trace disabled
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0); cycle();
        end
        drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0); cycle();
        check("coinc_frame_count", 64'(frame_count), 64'(15));
        check("coinc_dct_count",   64'(dct_count),   64'(1));
        check("coinc_dct_buffer",  64'(dct_buffer),  64'(2));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0); cycle();
        end
        check("disabled_dct_count", 64'(dct_count), 64'(1));
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0); cycle();
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(99) < 90), 1'($urandom_range(99) < 75),
                  2'($urandom_range(3)), 1'($urandom_range(99) < 5),
                  1'($urandom_range(99) < 55), 1'($urandom_range(99) < 3));
            cycle();
        end

        // Drain whatever is left
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0); cycle();
        idle(6);
        check("sb_drained", 64'(exp_q.size()), 64'(0));
        check("drain_dct_count", 64'(dct_count), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicore_sobel_cpu_1_oci_dct_packer.md
Name: multicore_sobel_cpu_1_oci_dct_packer

Overview:
- Packs 2-bit direct-conditional trace atoms (branch taken/not-taken) from CPU_1 into 30-bit frames of up to 15 atoms.
- Sits directly upstream of the OCI trace test bench and trace FIFO.
- Exposes the live accumulation buffer as dct_buffer/dct_count.
- Hands completed frames downstream over a valid/ready register slice.
- The trace source cannot stall, so the block drops atoms on overflow and flags each drop.

Parameters:
- ATOM_W, 2, width of one trace atom.
- MAX_ATOMS, 15, atoms per frame; MAX_ATOMS*ATOM_W = 30 = buffer width.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- trace_enable  input  1  qualifies atom_valid; buffer contents are retained while low.
- atom_valid  input  1  atom present this cycle.
- atom  input  2  atom code.
- flush  input  1  single-cycle pulse: close the current partial frame (indirect branch, exception, debug entry).
- frame_ready  input  1  downstream accepts frame.
- overflow_clr  input  1  clears overflow.
- frame_valid  output  1  frame slot occupied.
- frame_data  output  30  packed frame.
- frame_count  output  4  atoms in frame, 1..15.
- dct_buffer  output  30  live accumulation buffer.
- dct_count  output  4  live atom count, 0..15.
- overflow  output  1  sticky: at least one atom was dropped.

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs 0, flush_pend=0.
- Definitions:
  - acc = trace_enable & atom_valid.
  - slot_free = !frame_valid | frame_ready.
  - xfer = slot_free & (dct_count==15 | ((flush | flush_pend) & dct_count!=0)).
  - All terms are evaluated on registered state.
- Packing:
  - An accepted atom shifts in at the LSB: dct_buffer <= {dct_buffer[27:0], atom}; dct_count+1.
  - The oldest atom sits at the highest occupied bits; unused upper bits are always 0.
- On xfer:
  - frame_data <= dct_buffer, frame_count <= dct_count, frame_valid <= 1, flush_pend <= 0.
  - The buffer clears. If acc is also set that cycle, dct_buffer <= {28'b0, atom} and dct_count <= 1; otherwise 0/0.
- Frame handshake:
  - If frame_valid & frame_ready and there is no xfer, frame_valid <= 0.
  - frame_data/frame_count hold stable while frame_valid=1 and frame_ready=0.
  - Back-to-back frames are supported: accept and new xfer can occur in the same cycle.
- Latency: dct_count becomes 15 at edge N. If slot_free holds at N+1, the frame is visible at edge N+1.
- Flush:
  - A flush with dct_count==0 and flush_pend=0 has no effect.
  - A flush when xfer is blocked (slot busy) sets flush_pend.
  - Atoms accepted while flush_pend=1 still append to the pending frame.
  - A flush coincident with an accepted atom: the transfer takes the pre-atom buffer; the atom starts the next frame.
- Full buffer (dct_count==15), slot busy, acc=1:
  - The atom is dropped; the buffer is unchanged.
  - overflow <= 1.
- Overflow:
  - overflow_clr clears overflow.
  - If a drop and overflow_clr occur in the same cycle, set wins.
- trace_enable=0:
  - atom_valid is ignored.
  - flush and the frame handshake keep operating.
- dct_count never exceeds 15; there is no wrap-around.

Test Plan:
- Reset mid-frame: 7 atoms in, assert reset_n=0 asynchronously → all outputs 0 immediately, no frame emitted after release.
- 15 atoms of 2'b01 with frame_ready=1 → one cycle after the 15th edge: frame_valid=1, frame_data=30'h15555555, frame_count=15, dct_count=0.
- Atoms 2'b11, 2'b10, 2'b01, then flush → frame_data=30'h39, frame_count=3. A flush issued with dct_count=0 produces no frame.
- frame_ready=0 throughout, 31 atoms:
  - Frame 1 is held stable, buffer reaches 15.
  - Atom 31 is dropped and overflow=1.
  - Raise frame_ready → frame 1 is accepted and frame 2 (15 atoms) is presented the next cycle.
  - Pulse overflow_clr → overflow=0.
- Flush while slot busy with 4 atoms in buffer, 2 more atoms arrive, then release frame_ready → next frame has frame_count=6.
- Atom accepted in the same cycle as a count==15 transfer → frame_count=15 and dct_count=1 holding that atom. With trace_enable=0, atom_valid pulses leave dct_count unchanged.
